// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_rf_pkg
// Brief    : Shared limits and helpers for the multi-port RISC-V register file
// Revision : 1.0  initial release
// ============================================================================
package riscv_rf_pkg;

   // Supported port-count limits
   localparam int C_MAX_RD  = 4;
   localparam int C_MAX_WR  = 3;

   // Width of a write-port index able to address C_MAX_WR ports
   localparam int C_WIDX_W  = 2;

   // Default packed-slice geometry
   localparam int C_ADDR_W  = 5;
   localparam int C_DATA_W  = 32;

   // Highest set bit of a write-port match vector (0 when nothing matches)
   function automatic logic [C_WIDX_W-1:0] f_hi_port(input logic [C_MAX_WR-1:0] i_match);
      logic [C_WIDX_W-1:0] w_idx;
      w_idx = '0;
      for (int k = 0; k < C_MAX_WR; k++) begin
         if (i_match[k]) w_idx = C_WIDX_W'(k);
      end
      return w_idx;
   endfunction

   // Low bit of slice idx in a packed bus of equal-width fields
   function automatic int f_slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : riscv_rf_scoreboard
// Brief    : Per-register busy bits; reservations set, writebacks clear,
//            a same-cycle reservation overrides a completing writeback
// Revision : 1.0  initial release
// ============================================================================
module riscv_rf_scoreboard
   import riscv_rf_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_WR     = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] i_waddr,
   input  logic [NUM_WR-1:0]            i_we,
   input  logic                         i_resv,
   input  logic [ADDR_WIDTH-1:0]        i_resv_addr,
   output logic [(2**ADDR_WIDTH)-1:0]   o_busy
);

   localparam int NUM_WORDS = 2**ADDR_WIDTH;

   logic [NUM_WORDS-1:0] r_busy;
   logic [NUM_WORDS-1:0] w_clr;
   logic [NUM_WORDS-1:0] w_set;
   logic [NUM_WORDS-1:0] w_busy_nxt;

   // Decode set/clear masks; set is applied after clear so it wins
   always_comb begin
      w_clr = '0;
      w_set = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (i_we[p]) w_clr[i_waddr[f_slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
      if (i_resv) w_set[i_resv_addr] = 1'b1;
      w_busy_nxt = (r_busy & ~w_clr) | w_set;
      if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
   end

   // Busy state register
   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/riscv_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : riscv_register_file_mp
// Brief    : Flip-flop RISC-V integer register file, NUM_RD read / NUM_WR
//            write ports, optional zero register, optional write bypass and
//            a busy scoreboard for RAW hazard detection
// Revision : 1.0  initial release
// ============================================================================
module riscv_register_file_mp
   import riscv_rf_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 3,
   parameter int NUM_WR     = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
   output logic [NUM_RD-1:0]            rbusy_o,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic                         resv_i,
   input  logic [ADDR_WIDTH-1:0]        resv_addr_i,
   output logic                         wcoll_o
);

   localparam int NUM_WORDS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
   logic                  r_wcoll;
   logic                  w_coll;
   logic [NUM_WORDS-1:0]  w_busy;

   // Storage; ports applied in ascending order so the highest index wins
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < NUM_WORDS; w++) r_mem[w] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (we_i[p] &&
                !((ZERO_REG != 0) && (waddr_i[f_slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH] == '0)))
               r_mem[waddr_i[f_slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]]
                  <= wdata_i[f_slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

   // Detect two enabled ports hitting the same non-discarded register
   always_comb begin
      w_coll = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (we_i[i] && we_i[j] &&
                (waddr_i[f_slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] ==
                 waddr_i[f_slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH]) &&
                !((ZERO_REG != 0) && (waddr_i[f_slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == '0)))
               w_coll = 1'b1;
         end
      end
   end

   // Sticky collision flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) r_wcoll <= 1'b0;
      else     r_wcoll <= r_wcoll | w_coll;
   end

   assign wcoll_o = r_wcoll;

   riscv_rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WR     (NUM_WR),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .i_waddr     (waddr_i),
      .i_we        (we_i),
      .i_resv      (resv_i),
      .i_resv_addr (resv_addr_i),
      .o_busy      (w_busy)
   );

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
         logic [ADDR_WIDTH-1:0] w_ra;
         logic [C_MAX_WR-1:0]   w_match;
         logic                  w_zero;
         logic                  w_byp;
         logic [DATA_WIDTH-1:0] w_rdata;
         logic                  w_rbusy;

         // Read mux: zero register, then bypass network, then array
         always_comb begin
            w_ra    = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_match = '0;
            for (int q = 0; q < NUM_WR; q++) begin
               w_match[q] = we_i[q] && (waddr_i[f_slice_lo(q, ADDR_WIDTH) +: ADDR_WIDTH] == w_ra);
            end
            w_zero  = (ZERO_REG != 0) && (w_ra == '0);
            w_byp   = (BYPASS != 0) && (|w_match) && !w_zero;
            if (w_zero)
               w_rdata = '0;
            else if (w_byp)
               w_rdata = wdata_i[f_slice_lo(int'(f_hi_port(w_match)), DATA_WIDTH) +: DATA_WIDTH];
            else
               w_rdata = r_mem[w_ra];
            // A bypassed writeback hides the busy bit unless re-reserved now
            w_rbusy = w_busy[w_ra] && !(w_byp && !(resv_i && (resv_addr_i == w_ra)));
         end

         assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
         assign rbusy_o[p]                          = w_rbusy;
      end
   endgenerate

endmodule
`default_nettype wire
